onewire_fifo_tx: RTL

- Read-side consumer of the byte FIFO: pops bytes from the FIFO's read port and serialises them LSB-first onto the 1-wire bus as standard write slots.
- Also issues 1-wire reset pulses on request and samples the slave presence pulse.
- Sits between the FIFO output and the open-drain bus pad, under control of the host/command logic.

---
 rtl/onewire_pkg.sv | 28 ++
 rtl/onewire_slot_timer.sv | 35 +++
 rtl/onewire_fifo_tx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/onewire_pkg.sv
// Shared 1-wire definitions: controller states, default bus timings in
// microseconds, and the microsecond-to-clock-tick conversion.
package onewire_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_LOW,
    RST_WAIT,
    FETCH,
    LOAD,
    SLOT_LOW,
    SLOT_REC
  } ow_state_e;

  localparam int unsigned DEF_TICKS_PER_US     = 50;
  localparam int unsigned DEF_T_W1_LOW_US      = 6;
  localparam int unsigned DEF_T_W0_LOW_US      = 60;
  localparam int unsigned DEF_T_SLOT_US        = 70;
  localparam int unsigned DEF_T_RST_LOW_US     = 480;
  localparam int unsigned DEF_T_PRES_SAMPLE_US = 70;
  localparam int unsigned DEF_T_RST_REL_US     = 410;

  function automatic int unsigned us_to_ticks(input int unsigned us,
                                              input int unsigned ticks_per_us);
    return us * ticks_per_us;
  endfunction

endpackage

// File: rtl/onewire_slot_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module onewire_slot_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = (count_q == '0);

endmodule

// File: rtl/onewire_fifo_tx.sv
// 1-wire transmitter: drains the byte FIFO LSB-first as write slots and runs
// bus reset / presence-detect sequences on request.
module onewire_fifo_tx
  import onewire_pkg::*;
#(
  parameter int unsigned TICKS_PER_US     = DEF_TICKS_PER_US,
  parameter int unsigned T_W1_LOW_US      = DEF_T_W1_LOW_US,
  parameter int unsigned T_W0_LOW_US      = DEF_T_W0_LOW_US,
  parameter int unsigned T_SLOT_US        = DEF_T_SLOT_US,
  parameter int unsigned T_RST_LOW_US     = DEF_T_RST_LOW_US,
  parameter int unsigned T_PRES_SAMPLE_US = DEF_T_PRES_SAMPLE_US,
  parameter int unsigned T_RST_REL_US     = DEF_T_RST_REL_US
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       reset_req,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  input  logic [7:0] fifo_data,
  input  logic       ow_in,
  output logic       ow_drive_low,
  output logic       busy,
  output logic       presence,
  output logic       byte_done
);

  localparam int unsigned CNT_W = $clog2(T_RST_LOW_US * TICKS_PER_US + 1);

  // Timer load values are one less than the duration: a state is left on the
  // cycle its count reaches zero.
  localparam logic [CNT_W-1:0] RST_LOW_LD = CNT_W'(us_to_ticks(T_RST_LOW_US, TICKS_PER_US) - 1);
  localparam logic [CNT_W-1:0] RST_REL_LD = CNT_W'(us_to_ticks(T_RST_REL_US, TICKS_PER_US) - 1);
  localparam logic [CNT_W-1:0] PRES_CNT   =
    CNT_W'(us_to_ticks(T_RST_REL_US - T_PRES_SAMPLE_US, TICKS_PER_US));
  localparam logic [CNT_W-1:0] W1_LOW_LD  = CNT_W'(us_to_ticks(T_W1_LOW_US, TICKS_PER_US) - 1);
  localparam logic [CNT_W-1:0] W0_LOW_LD  = CNT_W'(us_to_ticks(T_W0_LOW_US, TICKS_PER_US) - 1);
  localparam logic [CNT_W-1:0] W1_REC_LD  =
    CNT_W'(us_to_ticks(T_SLOT_US - T_W1_LOW_US, TICKS_PER_US) - 1);
  localparam logic [CNT_W-1:0] W0_REC_LD  =
    CNT_W'(us_to_ticks(T_SLOT_US - T_W0_LOW_US, TICKS_PER_US) - 1);

  ow_state_e        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             presence_q, presence_d;
  logic             byte_done_q, byte_done_d;
  logic             ow_drive_low_q, ow_drive_low_d;
  logic             rd_c;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_done;

  onewire_slot_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    presence_d  = presence_q;
    byte_done_d = 1'b0;
    rd_c        = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state_q)
      IDLE: begin
        if (reset_req) begin
          state_d  = RST_LOW;
          tmr_load = 1'b1;
          tmr_val  = RST_LOW_LD;
        end else if (enable && !fifo_empty) begin
          rd_c    = 1'b1;
          state_d = FETCH;
        end
      end
      RST_LOW: begin
        if (tmr_done) begin
          state_d  = RST_WAIT;
          tmr_load = 1'b1;
          tmr_val  = RST_REL_LD;
        end
      end
      RST_WAIT: begin
        if (tmr_count == PRES_CNT) begin
          presence_d = !ow_in;
        end
        if (tmr_done) begin
          state_d = IDLE;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d   = fifo_data;
        bit_cnt_d = 3'd0;
        state_d   = SLOT_LOW;
        tmr_load  = 1'b1;
        tmr_val   = fifo_data[0] ? W1_LOW_LD : W0_LOW_LD;
      end
      SLOT_LOW: begin
        if (tmr_done) begin
          state_d  = SLOT_REC;
          tmr_load = 1'b1;
          tmr_val  = shift_q[0] ? W1_REC_LD : W0_REC_LD;
        end
      end
      SLOT_REC: begin
        if (tmr_done) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_done_d = 1'b1;
            if (enable && !fifo_empty) begin
              rd_c    = 1'b1;
              state_d = FETCH;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d  = SLOT_LOW;
            tmr_load = 1'b1;
            tmr_val  = shift_q[1] ? W1_LOW_LD : W0_LOW_LD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Pad enable follows the next state so it can be a plain flop output.
    ow_drive_low_d = (state_d == RST_LOW) || (state_d == SLOT_LOW);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      presence_q     <= 1'b0;
      byte_done_q    <= 1'b0;
      ow_drive_low_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      presence_q     <= presence_d;
      byte_done_q    <= byte_done_d;
      ow_drive_low_q <= ow_drive_low_d;
    end
  end

  // The pop strobe is decoded from IDLE, so hold it off while reset is low.
  assign fifo_rd      = rd_c & reset;
  assign ow_drive_low = ow_drive_low_q;
  assign busy         = (state_q != IDLE);
  assign presence     = presence_q;
  assign byte_done    = byte_done_q;

endmodule
